proc_phase_seq: RTL and testbench
=================================

# proc_phase_seq

Parametrised multi-cycle phase sequencer for the processor control path. It generalises the fixed five-state fetch/decode/execute/memory/write-back cycle with three additions:
- a memory ready handshake with wait states;
- an optional memory-phase skip for non-memory instructions;
- halt/resume, a retired-instruction counter and a stall watchdog.

It sits between the control unit's decode logic and the memory model, and drives the phase that the control unit's datapath actions key on.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter
- WAIT_W, 4, width of wait-state counter; timeout after 2^WAIT_W-1 consecutive not-ready cycles

Ports (one clock; reset is synchronous and active-high):
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  synchronous reset, active-high
- MEM_OP  input  2  memory need of the current instruction, sampled in EXE: 00 none, 01 read, 10 write, 11 treated as read
- MEM_READY  input  1  memory completes the current request this cycle
- HALT  input  1  halt request, sampled in WB and HALTED
- STATE  output  3  current phase: 0 FETCH, 1 DECODE, 2 EXE, 3 MEM, 4 WB, 5 HALTED, 6 ERR
- MEM_REQ  output  1  memory request active
- MEM_WE  output  1  request is a write (valid only with MEM_REQ)
- IR_LOAD  output  1  instruction register load strobe
- INSTR_CNT  output  CNT_W  retired instructions, wraps modulo 2^CNT_W
- ERR  output  1  watchdog tripped, sticky

## Operation
- Reset values: STATE=FETCH, MEM_REQ=1 (Moore from FETCH), MEM_WE=0, IR_LOAD=0, INSTR_CNT=0, ERR=0, internal op latch=00, wait counter=0.
- FETCH:
  - MEM_REQ=1, MEM_WE=0.
  - MEM_READY=1 → DECODE; IR_LOAD=1 that same cycle (Mealy: FETCH & MEM_READY).
  - Otherwise stay and increment the wait counter.
- DECODE: one cycle → EXE.
- EXE:
  - One cycle; latch MEM_OP into the op latch.
  - Next state is MEM, except as modified by Configuration.
- MEM:
  - If latched op ≠ 00: MEM_REQ=1; MEM_WE=1 iff latched op=10; MEM_READY=1 → WB, else stay and count waits.
  - If latched op = 00: MEM_REQ=0; unconditional → WB after one cycle.
- WB:
  - One cycle; INSTR_CNT increments by 1 (wraps 2^CNT_W-1 → 0).
  - HALT=1 → HALTED, else → FETCH.
- HALTED: MEM_REQ=0; stays while HALT=1; HALT=0 → FETCH.
- ERR: entered from FETCH or MEM when the wait counter reaches 2^WAIT_W-1 with MEM_READY still 0. ERR=1, MEM_REQ=0. Only RST exits.
- Wait counter:
  - Cleared on any MEM_READY=1 and on every state change.
  - Counts only in FETCH and in MEM with op ≠ 00.
- MEM_OP, HALT and MEM_READY are ignored outside the states that sample them.
- Unused encoding 7: next state FETCH, outputs as HALTED.
- MEM_REQ, MEM_WE, STATE and ERR are Moore outputs from registered state. IR_LOAD is the only combinational-from-input output.

## Timing
- With MEM_READY tied high: an instruction takes 5 cycles (FETCH, DECODE, EXE, MEM, WB), or 4 cycles when the memory phase is skipped.
- Each not-ready cycle in FETCH or in a real MEM access adds one cycle.
- INSTR_CNT updates on the clock edge leaving WB; its value is visible the cycle after WB.
- Watchdog with WAIT_W=4: 15 consecutive not-ready cycles in one state → STATE=ERR on the next edge. MEM_READY arriving on the 15th cycle wins (normal transition).
- RST=1 at any edge, mid-wait or mid-instruction included, returns everything to reset values on that edge. RST has priority over all transitions; ERR and INSTR_CNT are cleared.
- HALT asserted in any state other than WB and HALTED has no effect until WB is reached.

## Configuration
- PROC_SKIP_MEM_EN:
  - Defined: EXE with MEM_OP=00 goes directly to WB, skipping MEM (4-cycle non-memory instructions).
  - Undefined: EXE always goes to MEM, and a no-op MEM lasts exactly one cycle with MEM_REQ=0 (classic fixed 5-phase cycle).

## Test plan
- Reset then MEM_READY=1, MEM_OP=00, macro undefined: STATE sequence 0,1,2,3,4,0. IR_LOAD pulses once, in FETCH. INSTR_CNT=1 after the first WB, and 3 after 15 cycles.
- Same stimulus with PROC_SKIP_MEM_EN defined: sequence 0,1,2,4,0 with MEM never entered. INSTR_CNT=5 after 20 cycles.
- MEM_OP=10 in EXE, MEM_READY low for 3 cycles in MEM: MEM_REQ=1 and MEM_WE=1 for 4 cycles, then WB. Instruction latency is 8 cycles.
- MEM_READY held 0 in FETCH with WAIT_W=4: STATE=ERR and ERR=1 after 15 FETCH cycles, and it stays ERR for 20 more cycles. RST=1 for one edge → STATE=0, ERR=0, INSTR_CNT=0.
- HALT=1 raised during DECODE: enters HALTED only after WB and stays for 10 cycles with MEM_REQ=0. HALT=0 → FETCH next edge, and INSTR_CNT increments exactly once.
- CNT_W=4, 16 instructions: INSTR_CNT wraps 15→0. RST asserted in MEM mid-wait: next state is FETCH with the wait counter cleared.

Source files
------------

// File: rtl/proc_phase_seq_if.sv
// Sequencer <-> control/memory bus for proc_phase_seq.
// master: the sequencer side; slave: the control unit / memory model side.
interface proc_phase_seq_if #(
  parameter int unsigned CNT_W = 16
);
  logic [1:0]       MEM_OP;
  logic             MEM_READY;
  logic             HALT;
  logic [2:0]       STATE;
  logic             MEM_REQ;
  logic             MEM_WE;
  logic             IR_LOAD;
  logic [CNT_W-1:0] INSTR_CNT;
  logic             ERR;

  modport master (
    input  MEM_OP, MEM_READY, HALT,
    output STATE, MEM_REQ, MEM_WE, IR_LOAD, INSTR_CNT, ERR
  );

  modport slave (
    output MEM_OP, MEM_READY, HALT,
    input  STATE, MEM_REQ, MEM_WE, IR_LOAD, INSTR_CNT, ERR
  );
endinterface

// File: rtl/proc_phase_seq.sv
// Multi-cycle fetch/decode/exe/mem/wb phase sequencer with memory wait states,
// halt/resume, retired-instruction counter and stall watchdog. Macro: PROC_SKIP_MEM_EN.
module proc_phase_seq #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned WAIT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  proc_phase_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5,
    S_ERR    = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  // Trip value is one below all-ones: the current not-ready cycle completes the count.
  localparam logic [WAIT_W-1:0] WAIT_TRIP = {{(WAIT_W-1){1'b1}}, 1'b0};

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        op_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_access;
  logic              wait_expired;
  logic              wait_counting;

  assign mem_access    = (op_q != 2'b00);
  assign wait_expired  = !bus.MEM_READY && (wait_q == WAIT_TRIP);
  assign wait_counting = (state == S_FETCH) || ((state == S_MEM) && mem_access);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (bus.MEM_READY)     state_nxt = S_DECODE;
        else if (wait_expired) state_nxt = S_ERR;
      end
      S_DECODE: state_nxt = S_EXE;
      S_EXE: begin
`ifdef PROC_SKIP_MEM_EN
        state_nxt = (bus.MEM_OP == 2'b00) ? S_WB : S_MEM;
`else
        state_nxt = S_MEM;
`endif
      end
      S_MEM: begin
        if (!mem_access || bus.MEM_READY) state_nxt = S_WB;
        else if (wait_expired)            state_nxt = S_ERR;
      end
      S_WB:     state_nxt = bus.HALT ? S_HALTED : S_FETCH;
      S_HALTED: state_nxt = bus.HALT ? S_HALTED : S_FETCH;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    bus.MEM_REQ = 1'b0;
    bus.MEM_WE  = 1'b0;
    bus.IR_LOAD = 1'b0;
    bus.ERR     = 1'b0;
    case (state)
      S_FETCH: begin
        bus.MEM_REQ = 1'b1;
        bus.IR_LOAD = bus.MEM_READY;
      end
      S_MEM: begin
        bus.MEM_REQ = mem_access;
        bus.MEM_WE  = (op_q == 2'b10);
      end
      S_ERR:   bus.ERR = 1'b1;
      default: ;
    endcase
  end

  assign bus.STATE     = state;
  assign bus.INSTR_CNT = cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q   <= '0;
      wait_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state == S_EXE) op_q <= bus.MEM_OP;
      if (state == S_WB)  cnt_q <= cnt_q + 1'b1;
      if ((state_nxt != state) || bus.MEM_READY) begin
        wait_q <= '0;
      end else if (wait_counting) begin
        wait_q <= wait_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_proc_phase_seq.sv
// Scoreboard bench for proc_phase_seq: per-cycle expected outputs queued by directed stimulus.
module tb_proc_phase_seq;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WAIT_W = 4;

  localparam logic [2:0] FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3,
                         WB = 3'd4, HA = 3'd5, ER = 3'd6;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  proc_phase_seq_if #(.CNT_W(CNT_W)) bus ();

  proc_phase_seq #(.CNT_W(CNT_W), .WAIT_W(WAIT_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.master)
  );

  typedef struct {
    logic [2:0]       st;
    logic             req;
    logic             we;
    logic             irl;
    logic [CNT_W-1:0] cnt;
    logic             err;
    string            tag;
  } exp_t;

  exp_t             q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  string            tag = "reset";

  // Monitor: one expected record per observed cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.STATE !== e.st || bus.MEM_REQ !== e.req || bus.MEM_WE !== e.we ||
            bus.IR_LOAD !== e.irl || bus.INSTR_CNT !== e.cnt || bus.ERR !== e.err) begin
          n_bad++;
          $display("FAIL %s @%0t: got st=%0d req=%b we=%b irl=%b cnt=%0d err=%b, want st=%0d req=%b we=%b irl=%b cnt=%0d err=%b",
                   e.tag, $time, bus.STATE, bus.MEM_REQ, bus.MEM_WE, bus.IR_LOAD,
                   bus.INSTR_CNT, bus.ERR, e.st, e.req, e.we, e.irl, e.cnt, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

  task automatic cyc(input logic [2:0] st, input logic req, input logic we,
                     input logic rdy, input logic [1:0] mop, input logic hlt);
    exp_t e;
    @(posedge CLK); #1;
    RST           = 1'b0;
    bus.MEM_READY = rdy;
    bus.MEM_OP    = mop;
    bus.HALT      = hlt;
    e.st  = st;
    e.req = req;
    e.we  = we;
    e.irl = (st == FE) && rdy;
    e.cnt = exp_cnt;
    e.err = (st == ER);
    e.tag = tag;
    q.push_back(e);
    if (st == WB) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic rst_cyc();
    @(posedge CLK); #1;
    RST           = 1'b1;
    bus.MEM_READY = 1'b0;
    bus.MEM_OP    = 2'b00;
    bus.HALT      = 1'b0;
    exp_cnt       = '0;
  endtask

  // One instruction: fw not-ready FETCH cycles, mw not-ready MEM cycles.
  task automatic run_instr(input logic [1:0] mop, input int fw, input int mw, input logic hlt);
    logic we;
    bit   do_mem;
    we     = (mop == 2'b10);
    do_mem = 1'b1;
`ifdef PROC_SKIP_MEM_EN
    if (mop == 2'b00) do_mem = 1'b0;
`endif
    for (int i = 0; i < fw; i++) cyc(FE, 1'b1, 1'b0, 1'b0, ~mop, 1'b0);
    cyc(FE, 1'b1, 1'b0, 1'b1, ~mop, 1'b0);
    cyc(DE, 1'b0, 1'b0, 1'b1, ~mop, hlt);
    cyc(EX, 1'b0, 1'b0, 1'b1, mop, hlt);
    if (do_mem) begin
      if (mop == 2'b00) begin
        cyc(ME, 1'b0, 1'b0, 1'b1, ~mop, hlt);
      end else begin
        for (int i = 0; i < mw; i++) cyc(ME, 1'b1, we, 1'b0, ~mop, hlt);
        cyc(ME, 1'b1, we, 1'b1, ~mop, hlt);
      end
    end
    cyc(WB, 1'b0, 1'b0, 1'b0, ~mop, hlt);
  endtask

  initial begin
    bus.MEM_READY = 1'b0;
    bus.MEM_OP    = 2'b00;
    bus.HALT      = 1'b0;
    rst_cyc();
    rst_cyc();

    tag = "basic";      repeat (3) run_instr(2'b00, 0, 0, 1'b0);
    tag = "write_wait"; run_instr(2'b10, 0, 3, 1'b0);
    tag = "read_wait";  run_instr(2'b01, 2, 1, 1'b0);
    tag = "op11_read";  run_instr(2'b11, 0, 0, 1'b0);
    tag = "fetch_14";   run_instr(2'b00, 14, 0, 1'b0);
    tag = "mem_14";     run_instr(2'b01, 0, 14, 1'b0);

    tag = "halt";       run_instr(2'b00, 0, 0, 1'b1);
    repeat (10) cyc(HA, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
    cyc(HA, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    tag = "resume";     run_instr(2'b00, 0, 0, 1'b0);

    tag = "wrap";       repeat (8) run_instr(2'b00, 0, 0, 1'b0);

    tag = "rst_mem";
    cyc(FE, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    cyc(DE, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    cyc(EX, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    repeat (5) cyc(ME, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    rst_cyc();
    tag = "after_rst";  run_instr(2'b00, 14, 0, 1'b0);

    tag = "wdog_fetch";
    repeat (15) cyc(FE, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (20) cyc(ER, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
    rst_cyc();
    tag = "post_err";
    cyc(FE, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

    tag = "wdog_mem";
    cyc(FE, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    cyc(DE, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    cyc(EX, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    repeat (15) cyc(ME, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    repeat (3) cyc(ER, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    rst_cyc();
    tag = "final_rst";
    cyc(FE, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

    @(negedge CLK); #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
